// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Brief    : Interrupt controller for the multi-cycle MIPS core. Latches
//            rising edges on the irq lines, applies a mask and fixed
//            lowest-index-first priority, and walks the ControlUnit through
//            SAVE / SERVICE / RESTORE phases while supplying the vector.
//            Optional macro IRQ_SYNC_EN adds a two-flop synchronizer on
//            every irq line ahead of edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
    parameter int                 NUM_IRQ       = 4,
    parameter logic [31:0]        VECTOR_BASE   = 32'h0000_0080,
    parameter int unsigned        VECTOR_STRIDE = 8,
    parameter logic [NUM_IRQ-1:0] MASK_RESET    = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               instr_done,
    input  logic               ctx_done,
    input  logic               eret,
    output logic [1:0]         int_state,
    output logic               int_respond,
    output logic [31:0]        int_vector,
    output logic [2:0]         int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    // State encoding doubles as the int_state output value.
    localparam logic [1:0] c_st_normal  = 2'd0;
    localparam logic [1:0] c_st_save    = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;
    localparam logic [1:0] c_st_restore = 2'd3;

    logic [1:0]         r_state;
    logic               r_respond;
    logic [31:0]        r_vector;
    logic [2:0]         r_id;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq_q;

    logic [NUM_IRQ-1:0] w_irq_src;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_win_oh;
    logic [2:0]         w_win_id;
    logic               w_found;
    logic               w_accept;
    logic [31:0]        w_vector;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    // Two-flop synchronizer for asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_src = r_sync2;
`else
    assign w_irq_src = irq;
`endif

    assign w_edge     = w_irq_src & ~r_irq_q;
    assign w_eligible = r_pending & ~r_mask;

    // Fixed priority: the lowest eligible index wins.
    always_comb begin
        w_win_oh = '0;
        w_win_id = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_eligible[i] && !w_found) begin
                w_win_oh[i] = 1'b1;
                w_win_id    = 3'(i);
            end
            w_found = w_found | w_eligible[i];
        end
    end

    // Acceptance only happens at an instruction boundary while idle.
    assign w_accept = (r_state == c_st_normal) && instr_done && (|w_eligible);
    assign w_vector = VECTOR_BASE + (32'(w_win_id) * VECTOR_STRIDE);

    // Request history, pending latch and mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RESET;
        end else begin
            r_irq_q <= w_irq_src;
            // A new edge on the winning bit keeps it set (set wins).
            r_pending <= (r_pending & ~(w_accept ? w_win_oh : '0)) | w_edge;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // Sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_normal;
            r_respond <= 1'b0;
            r_vector  <= '0;
            r_id      <= '0;
        end else begin
            r_respond <= 1'b0;
            case (r_state)
                c_st_normal: begin
                    if (w_accept) begin
                        r_state   <= c_st_save;
                        r_respond <= 1'b1;
                        r_id      <= w_win_id;
                        r_vector  <= w_vector;
                    end
                end
                c_st_save: begin
                    if (ctx_done) begin
                        r_state <= c_st_service;
                    end
                end
                c_st_service: begin
                    if (eret) begin
                        r_state <= c_st_restore;
                    end
                end
                c_st_restore: begin
                    if (ctx_done) begin
                        r_state <= c_st_normal;
                    end
                end
                default: r_state <= c_st_normal;
            endcase
        end
    end

    assign int_state   = r_state;
    assign int_respond = r_respond;
    assign int_vector  = r_vector;
    assign int_id      = r_id;
    assign pending     = r_pending;
    assign mask        = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sequencer
// Brief    : Self-checking bench for irq_sequencer. Expected acceptances are
//            queued by the stimulus; a monitor pops one per int_respond.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

`ifdef IRQ_SYNC_EN
    localparam int c_lat = 4;
`else
    localparam int c_lat = 2;
`endif

    typedef struct {
        logic [2:0]  id;
        logic [31:0] vec;
        logic [3:0]  pend;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        instr_done;
    logic        ctx_done;
    logic        eret;
    logic [1:0]  int_state;
    logic        int_respond;
    logic [31:0] int_vector;
    logic [2:0]  int_id;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    irq_sequencer #(
        .NUM_IRQ      (4),
        .VECTOR_BASE  (32'h0000_0080),
        .VECTOR_STRIDE(8),
        .MASK_RESET   (4'b1111)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .instr_done (instr_done),
        .ctx_done   (ctx_done),
        .eret       (eret),
        .int_state  (int_state),
        .int_respond(int_respond),
        .int_vector (int_vector),
        .int_id     (int_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_accept(input logic [2:0] id, input logic [31:0] vec,
                                 input logic [3:0] pend, input int at);
        exp_t e;
        e.id   = id;
        e.vec  = vec;
        e.pend = pend;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},   32'(int_state),   32'd0);
        chk({tag, "_respond"}, 32'(int_respond), 32'd0);
        chk({tag, "_vector"},  int_vector,       32'd0);
        chk({tag, "_id"},      32'(int_id),      32'd0);
        chk({tag, "_pending"}, 32'(pending),     32'd0);
        chk({tag, "_mask"},    32'(mask),        32'hF);
    endtask

    // Monitor: every int_respond pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && int_respond === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_respond", 32'(int_id), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("acc_id",      32'(int_id),    32'(e.id));
                    chk("acc_vector",  int_vector,     e.vec);
                    chk("acc_pending", 32'(pending),   32'(e.pend));
                    chk("acc_state",   32'(int_state), 32'd1);
                    chk("acc_cycle",   32'(cyc),       32'(e.cyc));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        irq        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        instr_done = 1'b0;
        ctx_done   = 1'b0;
        eret       = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Masked request: latched in pending but never accepted.
        instr_done = 1'b1;
        irq        = 4'b0100;
        tick();
        irq = 4'b0000;
        repeat (6) tick();
        chk("masked_pending", 32'(pending),   32'b0100);
        chk("masked_state",   32'(int_state), 32'd0);

        // Fresh reset, then unmask everything.
        rst_n      = 1'b0;
        instr_done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mask_we    = 1'b1;
        mask_wdata = 4'b0000;
        tick();
        mask_we = 1'b0;
        chk("mask_write", 32'(mask), 32'd0);
        repeat (4) tick();

        // Two simultaneous requests: irq 1 wins.
        instr_done = 1'b1;
        irq        = 4'b1010;
        expect_accept(3'd1, 32'h88, 4'b1000, cyc + c_lat);
        repeat (c_lat) tick();
        chk("two_req_state",   32'(int_state), 32'd1);
        chk("two_req_pending", 32'(pending),   32'b1000);
        instr_done = 1'b0;
        irq        = 4'b0000;

        // eret in SAVE is ignored.
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret_in_save", 32'(int_state), 32'd1);
        ctx_done = 1'b1;
        tick();
        ctx_done = 1'b0;
        chk("to_service", 32'(int_state), 32'd2);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("to_restore", 32'(int_state), 32'd3);
        ctx_done = 1'b1;
        tick();
        ctx_done = 1'b0;
        chk("to_normal", 32'(int_state), 32'd0);
        tick();
        chk("idle_no_instr_done", 32'(int_state), 32'd0);

        // Next boundary picks up irq 3.
        expect_accept(3'd3, 32'h98, 4'b0000, cyc + 1);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("irq3_state", 32'(int_state), 32'd1);
        ctx_done = 1'b1;
        tick();
        ctx_done = 1'b0;
        eret = 1'b1;
        tick();
        eret     = 1'b0;
        ctx_done = 1'b1;
        tick();
        ctx_done = 1'b0;
        chk("irq3_done", 32'(int_state), 32'd0);

        // Latch irq 0, then re-raise it exactly on the acceptance edge,
        // with a mask write in the same cycle (old mask applies).
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        repeat (5) tick();
        chk("irq0_latched", 32'(pending), 32'b0001);
        irq = 4'b0001;
        repeat (c_lat - 2) tick();
        expect_accept(3'd0, 32'h80, 4'b0001, cyc + 1);
        instr_done = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 4'b0001;
        tick();
        instr_done = 1'b0;
        mask_we    = 1'b0;
        chk("set_wins_state",   32'(int_state), 32'd1);
        chk("set_wins_pending", 32'(pending),   32'b0001);
        chk("mask_after_acc",   32'(mask),      32'b0001);

        // Asynchronous reset in SERVICE aborts everything.
        ctx_done = 1'b1;
        tick();
        ctx_done = 1'b0;
        chk("service_before_rst", 32'(int_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        irq = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
